// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: RV32I major opcodes,
// the encoder's input class codes and the encoding formats.
package instr_encoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Shift-immediate funct3 (SLLI/SRLI/SRAI share the funct7 slot in imm[11:5])
  localparam logic [2:0] F3_SHIFT_R = 3'b101;

  typedef enum logic [3:0] {
    CLS_LW     = 4'd0,
    CLS_SW     = 4'd1,
    CLS_R      = 4'd2,
    CLS_IALU   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_class_e;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_R
  } instr_fmt_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: maps an instruction class plus raw fields to the
// 32-bit RV32I instruction word.
// Ports: in_class, funct3, funct7_5, rd, rs1, rs2, imm (inputs);
//        word (encoded instruction), illegal (class code 9-15).
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  in_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  instr_fmt_e  fmt;

  assign funct7 = {1'b0, funct7_5, 5'b0};

  // Right shifts by immediate carry the arithmetic/logical select in imm[11:5]
  assign imm_i = (in_class == CLS_IALU && funct3 == F3_SHIFT_R) ? {funct7, imm[4:0]} : imm[11:0];

  always_comb begin
    opcode  = 7'b0;
    fmt     = FMT_R;
    f3      = funct3;
    illegal = 1'b0;
    case (in_class)
      CLS_LW:     begin opcode = OP_LOAD;   fmt = FMT_I; end
      CLS_SW:     begin opcode = OP_STORE;  fmt = FMT_S; end
      CLS_R:      begin opcode = OP_RTYPE;  fmt = FMT_R; end
      CLS_IALU:   begin opcode = OP_IALU;   fmt = FMT_I; end
      CLS_BRANCH: begin opcode = OP_BRANCH; fmt = FMT_B; end
      CLS_JAL:    begin opcode = OP_JAL;    fmt = FMT_J; end
      CLS_JALR:   begin opcode = OP_JALR;   fmt = FMT_I; f3 = 3'b000; end
      CLS_LUI:    begin opcode = OP_LUI;    fmt = FMT_U; end
      CLS_AUIPC:  begin opcode = OP_AUIPC;  fmt = FMT_U; end
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    word = 32'b0;
    case (fmt)
      FMT_I:   word = {imm_i, rs1, f3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_R:   word = {funct7, rs2, rs1, f3, rd, opcode};
      default: word = 32'b0;
    endcase
    if (illegal) word = 32'b0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction loader: accepts field bundles over a valid/ready handshake,
// encodes them and writes consecutive words into an instruction memory.
// Ports: clk, reset (sync, active high), start/finish session pulses,
//        in_valid/in_ready handshake with in_class and instruction fields,
//        imem_we/imem_addr/imem_wdata memory write port,
//        count (words written), done, err_illegal (sticky).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  logic [1:0]        state;
  logic              we_q;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic [ADDR_W+1:0] used;

  instr_field_pack u_pack (
    .in_class (in_class),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .word     (word),
    .illegal  (illegal)
  );

  // Words already written plus the one registered for issue this cycle
  assign used     = {1'b0, count} + {{(ADDR_W+1){1'b0}}, we_q};
  assign in_ready = (state == ST_LOAD) && (used < DEPTH_W);
  assign accept   = in_valid && in_ready;
  assign done     = (state == ST_DONE);

  // A reset landing on the issue cycle must suppress the pending write
  assign imem_we = we_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'b0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      we_q  <= accept && !illegal;
      count <= count + {{ADDR_W{1'b0}}, we_q};
      if (accept && !illegal) begin
        imem_addr  <= used[ADDR_W-1:0];
        imem_wdata <= word;
      end
      if (accept && illegal) err_illegal <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD;
            count       <= '0;
            err_illegal <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Issuing the write that fills the last address also closes the session
          if (finish || (we_q && used == DEPTH_W)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            state       <= ST_LOAD;
            count       <= '0;
            err_illegal <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_class = 4'd0;
  logic [2:0]        funct3 = 3'd0;
  logic              funct7_5 = 1'b0;
  logic [4:0]        rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [31:0]       imm = 32'd0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done, err_illegal;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .funct3(funct3), .funct7_5(funct7_5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  // Reference model: session state (0 idle, 1 loading, 2 done), legal words accepted, sticky error
  int          mstate = 0, mcnt = 0;
  bit          merr = 1'b0;
  bit          use_forced = 1'b0;
  logic [31:0] forced_exp = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Encoding rules expressed as bit arithmetic on the RV32I field positions
  function automatic logic [31:0] ref_word(input logic [3:0] cls, input logic [2:0] f3,
                                           input logic f75, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [31:0] im);
    logic [31:0] op, f3w, dw, s1w, s2w, i12;
    f3w = 32'(f3) << 12;
    dw  = 32'(d) << 7;
    s1w = 32'(s1) << 15;
    s2w = 32'(s2) << 20;
    case (cls)
      4'd0: op = 32'h03;
      4'd1: op = 32'h23;
      4'd2: op = 32'h33;
      4'd3: op = 32'h13;
      4'd4: op = 32'h63;
      4'd5: op = 32'h6F;
      4'd6: op = 32'h67;
      4'd7: op = 32'h37;
      4'd8: op = 32'h17;
      default: op = 32'h0;
    endcase
    case (cls)
      4'd0, 4'd3, 4'd6: begin
        i12 = im & 32'hFFF;
        if (cls == 4'd3 && f3 == 3'd5) i12 = (32'(f75) << 10) | (im & 32'h1F);
        if (cls == 4'd6) f3w = 32'd0;
        return (i12 << 20) | s1w | f3w | dw | op;
      end
      4'd1: return (((im >> 5) & 32'h7F) << 25) | s2w | s1w | f3w | ((im & 32'h1F) << 7) | op;
      4'd2: return (32'(f75) << 30) | s2w | s1w | f3w | dw | op;
      4'd4: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | s2w | s1w | f3w
                   | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | op;
      4'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                   | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | dw | op;
      4'd7, 4'd8: return (im & 32'hFFFFF000) | dw | op;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every observed write must match the oldest expected write, in the expected cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_we === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=0x%08h, no write expected", imem_addr, imem_wdata);
        end else begin
          mon_e = sb.pop_front();
          check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
          check("write_data", imem_wdata, mon_e.data);
          check("write_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: none at cycle %0d, expected addr=%0d data=0x%08h", cyc, mon_e.addr, mon_e.data);
      end
    end
  end

  // One clock of stimulus; model updates follow what happens at the next rising edge
  task automatic step(input bit st, input bit fin, input bit v, input logic [3:0] cls,
                      input logic [2:0] f3, input logic f75, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    bit          acc;
    logic [31:0] w;
    @(posedge clk);
    #1;
    start = st; finish = fin; in_valid = v; in_class = cls; funct3 = f3;
    funct7_5 = f75; rd = d; rs1 = s1; rs2 = s2; imm = im;
    check("in_ready", 32'(in_ready), 32'(mstate == 1 && mcnt < DEPTH));
    if (sb.size() == 0) begin
      check("count", 32'(count), 32'(mcnt));
      check("done", 32'(done), 32'(mstate == 2));
      check("err_illegal", 32'(err_illegal), 32'(merr));
    end
    acc = v && (in_ready === 1'b1);
    if (acc) begin
      if (cls <= 4'd8) begin
        w = use_forced ? forced_exp : ref_word(cls, f3, f75, d, s1, s2, im);
        sb.push_back('{addr: mcnt, data: w, cyc: cyc + 1});
        mcnt++;
      end else begin
        merr = 1'b1;
      end
    end
    use_forced = 1'b0;
    if (mstate == 1) begin
      if (fin || mcnt == DEPTH) mstate = 2;
    end else if (st) begin
      mstate = 1;
      mcnt   = 0;
      merr   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_illegal", 32'(err_illegal), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed session: known words, an illegal class in between, finish with a bundle
    step(1, 0, 0, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    use_forced = 1'b1; forced_exp = 32'h00812283;
    step(0, 0, 1, 4'd0, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
    step(0, 0, 1, 4'd12, 3'd0, 1'b0, 5'd3, 5'd3, 5'd3, 32'd0);
    use_forced = 1'b1; forced_exp = 32'hFE208EE3;
    step(0, 0, 1, 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    use_forced = 1'b1; forced_exp = 32'h001000EF;
    step(0, 1, 1, 4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    idle(2);
    check("dir_count", 32'(count), 32'd3);
    check("dir_done", 32'(done), 32'd1);
    check("dir_err", 32'(err_illegal), 32'd1);

    // Restart clears everything; then overfill with six back-to-back bundles
    step(1, 0, 0, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle(1);
    check("restart_count", 32'(count), 32'd0);
    check("restart_err", 32'(err_illegal), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 1, 4'($urandom_range(0, 8)), 3'($urandom), 1'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), $urandom);
    idle(3);
    check("full_count", 32'(count), 32'd4);
    check("full_done", 32'(done), 32'd1);

    // Reset on the issue cycle of an accepted bundle
    step(1, 0, 0, 4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    step(0, 0, 1, 4'd3, 3'd5, 1'b1, 5'd7, 5'd8, 5'd0, 32'h0000001F);
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0;
    sb.delete();
    mstate = 0; mcnt = 0; merr = 1'b0;
    #1;
    check("we_during_reset", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;

    // Randomized sessions
    for (int i = 0; i < 3000; i++) begin
      bit          st, fin, v;
      logic [3:0]  cls;
      st  = (mstate != 1) && (sb.size() == 0) && ($urandom_range(0, 3) == 0);
      fin = (mstate == 1) && ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 3) != 0);
      cls = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      step(st, fin, v, cls, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), $urandom);
    end
    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, default 64, number of 32-bit instruction-memory words the block may write.
REQ-002 Parameter: ADDR_W, default 6, width of the word address; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse; begins a load session at word address 0.
REQ-006 Port: finish  input  1  one-cycle pulse; ends the load session.
REQ-007 Port: in_valid, in_ready  input/output  1 each  field-bundle handshake; transfer when both are high.
REQ-008 Port: in_class  input  4  0=LW, 1=SW, 2=R-type, 3=I-ALU, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC; 9-15 illegal.
REQ-009 Port: funct3 (3), funct7_5 (1), rd/rs1/rs2 (5 each), imm (32)  inputs  instruction fields.
REQ-010 Port: imem_we (1), imem_addr (ADDR_W), imem_wdata (32)  outputs  instruction-memory write port.
REQ-011 Port: count  output  ADDR_W+1  number of words written this session.
REQ-012 Port: done (1), err_illegal (1)  outputs  session complete; sticky illegal-class flag.

Function
REQ-013 Opcodes: LW 0000011, SW 0100011, R 0110011, I-ALU 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-014 Formats: LW/I-ALU/JALR I-type imm[11:0]; SW S-type imm[11:5],imm[4:0]; BRANCH B-type imm[12],imm[10:5],imm[4:1],imm[11]; JAL J-type imm[20],imm[10:1],imm[11],imm[19:12]; LUI/AUIPC U-type imm[31:12].
REQ-015 funct7 field = {1'b0, funct7_5, 5'b0} for R-type; for I-ALU with funct3=101, imm[11:5] is replaced by {1'b0, funct7_5, 5'b0}; JALR funct3 forced 000; unused fields zero.
REQ-016 FSM states IDLE, LOAD, DONE; reset enters IDLE.
REQ-017 IDLE: in_ready=0; start -> LOAD, count and write pointer cleared to 0.
REQ-018 LOAD: in_ready = 1 while count + pending < DEPTH, where pending = 1 while a write is registered but not yet issued.
REQ-019 Latency: bundle accepted in cycle T produces imem_we=1 in cycle T+1, with imem_addr = count and the encoded word; count increments at end of T+1.
REQ-020 Throughput: one bundle per cycle, back-to-back, no bubbles.
REQ-021 Illegal in_class: bundle consumed (handshake completes), no write, count unchanged, err_illegal set until next start or reset.
REQ-022 finish in LOAD -> DONE; a bundle accepted in the same cycle as finish is still written in the next cycle.
REQ-023 Full: the write that makes count = DEPTH moves the FSM to DONE in the same cycle; no write ever targets an address >= DEPTH.
REQ-024 DONE: done=1, in_ready=0, imem_we=0 except the final pending write; start -> LOAD restarting at address 0 and clearing done, count and err_illegal.
REQ-025 start in LOAD, finish in IDLE/DONE: ignored.
REQ-026 imem_wdata and imem_addr are don't-care when imem_we=0 but SHALL hold last values (no X).

Reset
REQ-027 On reset: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err_illegal=0, pending cleared.
REQ-028 Reset mid-session discards any pending write; imem_we is 0 in the cycle after reset asserts.

Structure
REQ-029 Shared package holds the 7-bit opcode constants, the in_class enumeration, and the format enumeration (I, S, B, J, U, R) reused by the main decoder.
REQ-030 One combinational sub-module, instr_field_pack, maps (class, fields) to the 32-bit word plus an illegal flag; instr_encoder holds the FSM, pending register and counter.

Verification
REQ-031 start; LW rd=5 rs1=2 imm=8 -> next cycle imem_we=1, addr=0, wdata=0x00812283.
REQ-032 BRANCH funct3=000 rs1=1 rs2=2 imm=-4 -> wdata=0xFE208EE3; JAL rd=1 imm=2048 -> wdata=0x001000EF.
REQ-033 DEPTH=4, 6 back-to-back bundles -> writes to addresses 0..3 on consecutive cycles, in_ready low after the 4th accept, done=1, count=4.
REQ-034 in_class=12 between two valid bundles -> err_illegal=1, the two valid words at addresses 0 and 1, count=2.
REQ-035 Bundle and finish in same cycle -> word written next cycle, then done=1; start -> count=0, err_illegal=0, next write at address 0.
REQ-036 reset asserted the cycle after an accept -> no write issued, all outputs at reset values.
